// File: rtl/uart_instr_loader.sv
// Boot loader: receives a length byte and 16-bit words over UART and writes them
// into the two 256x8 instruction SRAMs, then pulses start to release the core.
module uart_instr_loader #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic        rx,
    output logic        mem_sel,
    output logic        memw_en,
    output logic [7:0]  memw_en_8bit,
    output logic [7:0]  mem_addr,
    output logic [15:0] write_data,
    output logic [8:0]  word_count,
    output logic        done,
    output logic        start,
    output logic        frame_err
);
    localparam int CW = $clog2(CLKS_PER_BIT);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [2:0] {WAIT_LEN, WAIT_LSB, WAIT_MSB, WRITE, DONE} top_state_t;

    rx_state_t  rx_state, rx_next;
    top_state_t state, state_next;

    logic          rx_s1, rx_s2, rx_q;
    logic          rx_fall, tick;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    rx_byte;
    logic          byte_valid;
    logic [8:0]    total;
    logic          done_d;
    logic          wr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_q  <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_q  <= rx_s2;
        end
    end

    // A falling edge needs rx seen high first, so after a bad stop bit the
    // receiver naturally waits for the line to return high.
    assign rx_fall = rx_q & ~rx_s2;
    assign tick    = (rx_state == RX_START) ? (cnt == CW'(CLKS_PER_BIT/2 - 1))
                                            : (cnt == CW'(CLKS_PER_BIT - 1));

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (tick) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_idx == 3'd7) rx_next = RX_STOP;
            RX_STOP:  if (tick) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
        if (!enable) rx_next = RX_IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            rx_byte    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else if (!enable) begin
            rx_state   <= RX_IDLE;
            cnt        <= '0;
            bit_idx    <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_next;
            cnt        <= (rx_state == RX_IDLE || tick) ? '0 : cnt + 1'b1;
            byte_valid <= (rx_state == RX_STOP) && tick && rx_s2;
            if (rx_state == RX_STOP && tick && !rx_s2) frame_err <= 1'b1;
            if (rx_state == RX_DATA) begin
                if (tick) begin
                    rx_byte <= {rx_s2, rx_byte[7:1]};
                    bit_idx <= bit_idx + 3'd1;
                end
            end else begin
                bit_idx <= '0;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            WAIT_LEN: if (byte_valid) state_next = WAIT_LSB;
            WAIT_LSB: if (byte_valid) state_next = WAIT_MSB;
            WAIT_MSB: if (byte_valid) state_next = WRITE;
            WRITE:    state_next = (word_count + 9'd1 == total) ? DONE : WAIT_LSB;
            DONE:     state_next = DONE;
            default:  state_next = WAIT_LEN;
        endcase
        if (!enable) state_next = WAIT_LEN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= WAIT_LEN;
        else       state <= state_next;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            total      <= '0;
            write_data <= '0;
            mem_addr   <= '0;
            word_count <= '0;
            done_d     <= 1'b0;
        end else if (!enable) begin
            total      <= '0;
            write_data <= '0;
            mem_addr   <= '0;
            word_count <= '0;
            done_d     <= 1'b0;
        end else begin
            done_d <= (state == DONE);
            case (state)
                WAIT_LEN: if (byte_valid) total <= {1'b0, rx_byte} + 9'd1;
                WAIT_LSB: if (byte_valid) write_data[7:0]  <= rx_byte;
                WAIT_MSB: if (byte_valid) write_data[15:8] <= rx_byte;
                WRITE: begin
                    mem_addr   <= mem_addr + 8'd1;
                    word_count <= word_count + 9'd1;
                end
                default: ;
            endcase
        end
    end

    // Gating with enable suppresses a write whose cycle coincides with an abort;
    // the state reset makes the strobes drop asynchronously on reset.
    assign wr           = (state == WRITE) && enable;
    assign mem_sel      = ~wr;
    assign memw_en      = ~wr;
    assign memw_en_8bit = {8{~wr}};
    assign done         = (state == DONE);
    assign start        = done && !done_d;
endmodule

// File: tb/tb_uart_instr_loader.sv
// Directed bench for uart_instr_loader: drives UART frames and checks SRAM writes,
// done/start, framing errors, abort and asynchronous reset behaviour.
module tb_uart_instr_loader;
    localparam int CLKS = 8;

    logic        clk = 1'b0;
    logic        reset, enable, rx;
    logic        mem_sel, memw_en, done, start, frame_err;
    logic [7:0]  memw_en_8bit, mem_addr;
    logic [15:0] write_data;
    logic [8:0]  word_count;

    uart_instr_loader #(.CLKS_PER_BIT(CLKS)) dut (
        .clk(clk), .reset(reset), .enable(enable), .rx(rx),
        .mem_sel(mem_sel), .memw_en(memw_en), .memw_en_8bit(memw_en_8bit),
        .mem_addr(mem_addr), .write_data(write_data), .word_count(word_count),
        .done(done), .start(start), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // write / strobe monitor
    logic [7:0]  wa [0:1023];
    logic [15:0] wd [0:1023];
    int wr_n = 0, long_wr = 0, en_bad = 0, start_n = 0, start_long = 0;
    logic prev_low = 1'b0, prev_start = 1'b0;

    always @(negedge clk) begin
        if (!reset) begin
            if (!mem_sel) begin
                if (wr_n < 1024) begin
                    wa[wr_n] <= mem_addr;
                    wd[wr_n] <= write_data;
                end
                wr_n <= wr_n + 1;
                if (prev_low) long_wr <= long_wr + 1;
            end
            if (memw_en !== mem_sel || memw_en_8bit !== {8{mem_sel}}) en_bad <= en_bad + 1;
            if (start) begin
                start_n <= start_n + 1;
                if (prev_start) start_long <= start_long + 1;
            end
        end
        prev_low   <= !mem_sel;
        prev_start <= start;
    end

    task automatic bit_out(input logic v);
        rx = v;
        repeat (CLKS) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
        bit_out(stop);
        if (!stop) bit_out(1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_sel"},  mem_sel, 1);
        check({tag, "_gwen"}, memw_en, 1);
        check({tag, "_wen"},  memw_en_8bit, 8'hFF);
        check({tag, "_addr"}, mem_addr, 0);
        check({tag, "_data"}, write_data, 0);
        check({tag, "_wc"},   word_count, 0);
        check({tag, "_done"}, {done, start, frame_err}, 0);
    endtask

    task automatic rearm();
        enable = 1'b0;
        idle(3);
        enable = 1'b1;
        idle(2);
    endtask

    initial begin
        int base, sbase, nerr;
        logic [7:0] ib;
        logic found;
        reset = 1'b1; enable = 1'b0; rx = 1'b1;
        idle(4);
        check_reset_vals("rst");
        reset = 1'b0;
        idle(2);
        enable = 1'b1;
        idle(2);

        // two-word load
        base = wr_n; sbase = start_n;
        send_byte(8'h01); send_byte(8'h34); send_byte(8'h12);
        send_byte(8'hCD); send_byte(8'hAB);
        idle(10);
        check("t1_nwr", wr_n - base, 2);
        check("t1_a0", wa[base], 8'h00);
        check("t1_d0", wd[base], 16'h1234);
        check("t1_a1", wa[base+1], 8'h01);
        check("t1_d1", wd[base+1], 16'hABCD);
        check("t1_done", done, 1);
        check("t1_wc", word_count, 9'd2);
        check("t1_start_n", start_n - sbase, 1);
        check("t1_start_now", start, 0);

        // full 256-word load
        rearm();
        base = wr_n;
        send_byte(8'hFF);
        for (int i = 0; i < 256; i++) begin
            ib = i[7:0];
            send_byte(ib);
            send_byte(~ib);
        end
        idle(10);
        check("t2_nwr", wr_n - base, 256);
        nerr = 0;
        for (int i = 0; i < 256; i++) begin
            ib = i[7:0];
            if (wa[base+i] !== ib || wd[base+i] !== {~ib, ib}) nerr++;
        end
        check("t2_addrdata_err", nerr, 0);
        check("t2_addr_wrap", mem_addr, 8'h00);
        check("t2_wc", word_count, 9'd256);
        check("t2_done", done, 1);

        // short low glitch is rejected
        rearm();
        base = wr_n;
        rx = 1'b0;
        idle(CLKS/4);
        rx = 1'b1;
        idle(4*CLKS);
        check("t3_nwr", wr_n - base, 0);
        check("t3_ferr", frame_err, 0);
        check("t3_wc", word_count, 0);

        // bad stop bit, then a one-word load
        send_byte(8'h77, 1'b0);
        check("t4_ferr_set", frame_err, 1);
        send_byte(8'h00); send_byte(8'h5A); send_byte(8'h5A);
        idle(10);
        check("t4_nwr", wr_n - base, 1);
        check("t4_a0", wa[base], 8'h00);
        check("t4_d0", wd[base], 16'h5A5A);
        check("t4_ferr_sticky", frame_err, 1);
        check("t4_done", done, 1);

        // abort mid-word, then reload
        rearm();
        base = wr_n;
        send_byte(8'h01); send_byte(8'h34);
        enable = 1'b0;
        idle(3);
        check("t5_nwr", wr_n - base, 0);
        check_reset_vals("t5_abort");
        enable = 1'b1;
        idle(2);
        sbase = start_n;
        send_byte(8'h01); send_byte(8'h11); send_byte(8'h22);
        send_byte(8'h33); send_byte(8'h44);
        idle(10);
        check("t5_nwr2", wr_n - base, 2);
        check("t5_a0", wa[base], 8'h00);
        check("t5_d0", wd[base], 16'h2211);
        check("t5_a1", wa[base+1], 8'h01);
        check("t5_d1", wd[base+1], 16'h4433);
        check("t5_done", {done, word_count}, {1'b1, 9'd2});
        check("t5_start_n", start_n - sbase, 1);

        // asynchronous reset landing on a WRITE cycle
        rearm();
        send_byte(8'h00); send_byte(8'hC3);
        found = 1'b0;
        fork
            send_byte(8'h3C);
            begin
                for (int k = 0; k < 20*CLKS && !found; k++) begin
                    @(negedge clk);
                    if (!mem_sel) found = 1'b1;
                end
                if (found) begin
                    reset = 1'b1;
                    #1;
                    check("t6_sel_async", mem_sel, 1);
                    check("t6_gwen_async", memw_en, 1);
                    check("t6_wen_async", memw_en_8bit, 8'hFF);
                end else begin
                    check("t6_wr_seen", 0, 1);
                end
            end
        join
        idle(2);
        check_reset_vals("t6_rst");
        reset = 1'b0;
        idle(2);

        check("mon_long_wr", long_wr, 0);
        check("mon_en_bad", en_bad, 0);
        check("mon_start_long", start_long, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
